// File: rtl/pipe_addsub_pkg.sv
// Shared package for the pipelined adder/subtractor: operation encoding and
// the WIDTH/STAGES legality check used at elaboration.
package pipe_addsub_pkg;

    typedef enum logic [1:0] {
        OpAdd    = 2'b00,  // X + Y
        OpSubXY  = 2'b01,  // X - Y
        OpSubYX  = 2'b10,  // Y - X
        OpAddCin = 2'b11   // X + Y + Cin
    } addsub_op_t;

    // True when the operand width splits evenly into the requested segments.
    function automatic bit stages_ok(input int unsigned width, input int unsigned stages);
        return (stages != 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry segment: plain ripple add of two SEG_W-bit slices plus carry-in.
module addsub_seg #(
    parameter int unsigned SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor. Each stage adds one SEG_W-bit segment using the
// carry registered by the stage before it; unprocessed operand bits travel
// along so the finished sum is time-aligned at the output. Valid/ready
// handshake on both sides, with bubble collapsing when downstream stalls.
// Optional Zero/Ovf flag logic is built when PIPE_ADDSUB_FLAGS_EN is defined;
// otherwise both flags are tied to 0.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       Op,
    input  logic             Cin,
    input  logic             InValid,
    output logic             InReady,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             Zero,
    output logic             Ovf
);

    localparam int unsigned SEG_W = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    addsub_op_t       op;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic             hole;

    // Map the operation onto a single A + B + cin form (subtract = A + ~B + 1)
    always_comb begin
        op      = addsub_op_t'(Op);
        eff_a   = X;
        eff_b   = Y;
        eff_cin = 1'b0;
        unique case (op)
            OpAdd:    ;
            OpSubXY:  begin
                eff_b   = ~Y;
                eff_cin = 1'b1;
            end
            OpSubYX:  begin
                eff_a   = Y;
                eff_b   = ~X;
                eff_cin = 1'b1;
            end
            OpAddCin: eff_cin = Cin;
            default:  ;
        endcase
    end

    // A stage advances if it or any stage downstream of it is empty, or the sink takes data
    always_comb begin
        adv  = '0;
        hole = OutReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole | ~v_q[k];
            adv[k] = hole;
        end
    end

    assign InReady  = adv[0];
    assign OutValid = v_q[LAST];

    // Valid bits: cleared by reset or Flush, otherwise shifted wherever a stage advances
    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            v_q <= '0;
        end else begin
            if (adv[0]) v_q[0] <= InValid;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) v_q[k] <= v_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added, lowest segment at bit 0
        localparam int unsigned IN_W = WIDTH - k * SEG_W;

        logic [IN_W-1:0]          a_in;
        logic [IN_W-1:0]          b_in;
        logic                     c_in;
        logic [SEG_W-1:0]         seg_sum;
        logic                     seg_co;
        logic [(k+1)*SEG_W-1:0]   s_next;
        logic [(k+1)*SEG_W-1:0]   s_q;
        logic                     c_q;

        if (k == 0) begin : g_head
            assign a_in   = eff_a;
            assign b_in   = eff_b;
            assign c_in   = eff_cin;
            assign s_next = seg_sum;
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign s_next = {seg_sum, g_stage[k-1].s_q};
        end

        addsub_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a    (a_in[SEG_W-1:0]),
            .b    (b_in[SEG_W-1:0]),
            .cin  (c_in),
            .sum  (seg_sum),
            .cout (seg_co)
        );

        // Capture the completed low sum bits and this segment's carry
        always_ff @(posedge clk) begin
            if (adv[k]) begin
                s_q <= s_next;
                c_q <= seg_co;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [IN_W-SEG_W-1:0] a_q;
            logic [IN_W-SEG_W-1:0] b_q;

            // Forward the not-yet-added operand bits, shifted down one segment
            always_ff @(posedge clk) begin
                if (adv[k]) begin
                    a_q <= a_in[IN_W-1:SEG_W];
                    b_q <= b_in[IN_W-1:SEG_W];
                end
            end
        end else begin : g_tail
            assign S  = s_q;
            assign CO = c_q;
`ifdef PIPE_ADDSUB_FLAGS_EN
            logic zero_q;
            logic ovf_q;

            // Flags from the final segment; top operand/sum bits are the original MSBs
            always_ff @(posedge clk) begin
                if (adv[k]) begin
                    zero_q <= (s_next == '0);
                    ovf_q  <= (a_in[SEG_W-1] == b_in[SEG_W-1]) &&
                              (seg_sum[SEG_W-1] != a_in[SEG_W-1]);
                end
            end

            assign Zero = zero_q;
            assign Ovf  = ovf_q;
`else
            assign Zero = 1'b0;
            assign Ovf  = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (WIDTH=64, STAGES=4).
module tb_pipe_addsub;

    logic        clk = 1'b0;
    logic        reset, Flush, Cin, InValid, InReady, OutValid, OutReady, CO, Zero, Ovf;
    logic [63:0] X, Y, S;
    logic [1:0]  Op;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPE_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_addsub #(
        .WIDTH  (64),
        .STAGES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Flush    (Flush),
        .X        (X),
        .Y        (Y),
        .Op       (Op),
        .Cin      (Cin),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .S        (S),
        .CO       (CO),
        .Zero     (Zero),
        .Ovf      (Ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: checks exact 4-cycle latency and all result fields.
    task automatic run_one(input string tag, input logic [63:0] x, input logic [63:0] y,
                           input logic [1:0] op, input logic cin, input logic [63:0] es,
                           input logic eco, input logic ez, input logic eov);
        X = x; Y = y; Op = op; Cin = cin; InValid = 1'b1; OutReady = 1'b1;
        chk({tag, "_inready"}, InReady, 1);
        step();
        InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_valid"}, OutValid, 0);
            step();
        end
        chk({tag, "_outvalid"}, OutValid, 1);
        chk({tag, "_s"}, S, es);
        chk({tag, "_co"}, CO, eco);
        chk({tag, "_zero"}, Zero, FLAGS & ez);
        chk({tag, "_ovf"}, Ovf, FLAGS & eov);
        step();
        chk({tag, "_drained"}, OutValid, 0);
    endtask

    int seen;

    // Three ops in flight, then Flush (or reset) with a fourth op presented.
    task automatic kill_test(input string tag, input bit use_reset);
        OutReady = 1'b1;
        Op = 2'b00; Cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            X = 64'(i + 10); Y = 64'(i + 20); InValid = 1'b1;
            step();
        end
        X = 64'd99; Y = 64'd1; InValid = 1'b1;
        Flush = 1'b1;
        reset = use_reset;
        step();
        Flush = 1'b0; reset = 1'b0; InValid = 1'b0;
        chk({tag, "_outvalid_cleared"}, OutValid, 0);
        chk({tag, "_inready"}, InReady, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (OutValid) seen++;
            step();
        end
        chk({tag, "_ghosts"}, 64'(seen), 0);
        run_one({tag, "_after"}, 64'd1000, 64'd234, 2'b00, 1'b0, 64'd1234, 1'b0, 1'b0, 1'b0);
    endtask

    logic [63:0] sx [8];
    logic [63:0] sy [8];
    logic [63:0] se [8];
    logic [1:0]  sop [8];
    int          sent, recv, cyc;
    bit          fell, acc, fire;

    initial begin
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        X = '0; Y = '0; Op = 2'b00; Cin = 1'b0;
        step();
        step();
        chk("reset_outvalid", OutValid, 0);
        chk("reset_inready", InReady, 1);
        reset = 1'b0;
        step();

        run_one("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0,
                64'd0, 1'b1, 1'b1, 1'b0);
        run_one("sub_xy", 64'd5, 64'd7, 2'b01, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_yx", 64'd5, 64'd7, 2'b10, 1'b0,
                64'd2, 1'b1, 1'b0, 1'b0);
        run_one("addc_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 2'b11, 1'b1,
                64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        run_one("add_cin_ignored", 64'd3, 64'd4, 2'b00, 1'b1,
                64'd7, 1'b0, 1'b0, 1'b0);
        run_one("addc_mid_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 2'b11, 1'b1,
                64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0);
        run_one("sub_min_ovf", 64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        run_one("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b01, 1'b0,
                64'd0, 1'b1, 1'b1, 1'b0);

        // Streaming with a downstream stall on cycles 3..7
        for (int i = 0; i < 8; i++) begin
            sx[i]  = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
            sy[i]  = 64'hFEDC_BA98_0000_0000 >> i;
            sop[i] = (i % 2 == 1) ? 2'b01 : 2'b00;
            se[i]  = (i % 2 == 1) ? (sx[i] - sy[i]) : (sx[i] + sy[i]);
        end
        sent = 0; recv = 0; cyc = 0; fell = 1'b0; Cin = 1'b0;
        while ((recv < 8) && (cyc < 60)) begin
            OutReady = !((cyc >= 3) && (cyc <= 7));
            InValid  = (sent < 8);
            if (sent < 8) begin
                X = sx[sent]; Y = sy[sent]; Op = sop[sent];
            end
            #1;
            if (!InReady && !fell) begin
                fell = 1'b1;
                chk("stream_inready_fall_after", 64'(sent), 64'd4);
            end
            if (OutValid) chk("stream_s_in_order", S, se[recv]);
            acc  = InValid && InReady;
            fire = OutValid && OutReady;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (fire) recv++;
            cyc++;
        end
        InValid = 1'b0;
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_recv", 64'(recv), 64'd8);
        chk("stream_inready_fell", 64'(fell), 64'd1);
        step();
        chk("stream_no_dup", OutValid, 0);

        kill_test("flush", 1'b0);
        kill_test("reset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
